// File: rtl/msrv32_rf_write_arbiter.sv
// rtl/msrv32_rf_write_arbiter.sv - register-file write-port arbiter: writeback priority, buffered debug writes
// Optional starvation guard for the debug FIFO: define MSRV32_RF_STARVE_GUARD_EN.
module msrv32_rf_write_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             wb_valid_in,
  output logic             wb_ready_out,
  input  logic [4:0]       wb_rd_addr_in,
  input  logic [31:0]      wb_rd_in,
  input  logic             dbg_valid_in,
  output logic             dbg_ready_out,
  input  logic [4:0]       dbg_rd_addr_in,
  input  logic [31:0]      dbg_rd_in,
  output logic             wr_en_out,
  output logic [4:0]       rd_addr_out,
  output logic [31:0]      rd_out,
  output logic [CNT_W-1:0] dbg_pending_out,
  output logic             busy_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
    $error("msrv32_rf_write_arbiter: bad FIFO_DEPTH or STARVE_LIMIT");
  end

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  wr_req_t          mem_q [FIFO_DEPTH];
  wr_req_t          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [31:0]      rd_q, rd_d;

  logic    fifo_empty, fifo_full, force_grant;
  logic    wb_grant, dbg_grant, push;
  wr_req_t head, win;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head       = mem_q[rd_ptr_q];

`ifdef MSRV32_RF_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_grant = (starve_q == STARVE_MAX) && !fifo_empty;

  // Counts writeback wins only while debug is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || dbg_grant) begin
      starve_d = '0;
    end else if (wb_grant && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_grant = 1'b0;
`endif

  assign wb_ready_out  = !force_grant && !reset_in;
  assign dbg_ready_out = !fifo_full && !reset_in;
  assign wb_grant      = wb_ready_out && wb_valid_in;
  assign dbg_grant     = !reset_in && !fifo_empty && !wb_grant;
  assign push          = dbg_valid_in && dbg_ready_out;

  assign win = wb_grant ? wr_req_t'{wb_rd_addr_in, wb_rd_in} : head;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_req_t'{dbg_rd_addr_in, dbg_rd_in};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (dbg_grant) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, dbg_grant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A grant to x0 is consumed but never reaches the register file.
  always_comb begin
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_d      = rd_q;
    if (wb_grant || dbg_grant) begin
      wr_en_d   = (win.addr != 5'd0);
      rd_addr_d = win.addr;
      rd_d      = win.data;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_q      <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_q      <= rd_d;
    end
  end

  assign wr_en_out       = wr_en_q;
  assign rd_addr_out     = rd_addr_q;
  assign rd_out          = rd_q;
  assign dbg_pending_out = count_q;
  assign busy_out        = !fifo_empty || wr_en_q;

endmodule

// File: doc/msrv32_rf_write_arbiter.md
# msrv32_rf_write_arbiter

Arbiter and scheduler for the single write port of `msrv32_integer_file`. It shares the port between two requesters:
- the core writeback stage (priority requester);
- a debug/host write requester, buffered in a small FIFO.

The winning request is registered onto the register file's `rd_addr_in` / `rd_in` / `wr_en_in` inputs. Writes to x0 are filtered, and an optional starvation guard bounds debug latency.

## Interface
- `FIFO_DEPTH`, 2, debug FIFO entries; power of two, ≥2
- `STARVE_LIMIT`, 4, consecutive writeback grants tolerated while debug waits; ≥1
- `CNT_W`, log2(FIFO_DEPTH)+1, width of the occupancy count
- `clk_in` input 1, single clock, all state on rising edge
- `reset_in` input 1, synchronous, active-high reset
- `wb_valid_in` input 1, writeback write request
- `wb_ready_out` output 1, writeback request accepted this cycle
- `wb_rd_addr_in` input 5, writeback destination register
- `wb_rd_in` input 32, writeback data
- `dbg_valid_in` input 1, debug write request
- `dbg_ready_out` output 1, FIFO can accept a debug request
- `dbg_rd_addr_in` input 5, debug destination register
- `dbg_rd_in` input 32, debug data
- `wr_en_out` output 1, to register file `wr_en_in`
- `rd_addr_out` output 5, to register file `rd_addr_in`
- `rd_out` output 32, to register file `rd_in`
- `dbg_pending_out` output CNT_W, FIFO occupancy
- `busy_out` output 1, FIFO non-empty or `wr_en_out` high

## Operation
- **Debug enqueue:** a debug request enters the FIFO when `dbg_valid_in && dbg_ready_out`.
  - `dbg_ready_out = !full && !reset_in`.
  - No fall-through: an entry pushed in cycle N is eligible for grant from cycle N+1.
- **Grant selection, evaluated each cycle:**
  - **Force:** guard compiled in, starve counter == STARVE_LIMIT, FIFO non-empty. The FIFO head is granted and `wb_ready_out = 0`.
  - **Otherwise, writeback:** if `wb_valid_in`, writeback is granted. `wb_ready_out` is 1 whenever there is no force and no reset, independent of `wb_valid_in`.
  - **Otherwise, debug:** if the FIFO is non-empty, the head is granted and popped.
- **Output register:** the granted request is registered on the next edge into `rd_addr_out` / `rd_out`.
  - `wr_en_out <= granted && addr != 0`.
  - A grant to x0 is consumed (accepted or popped) but produces `wr_en_out = 0`.
  - With no grant, `wr_en_out <= 0`; `rd_addr_out` / `rd_out` hold their values.
- **Starve counter:**
  - Increments, saturating at STARVE_LIMIT, on each writeback grant while the FIFO is non-empty.
  - Clears on a debug pop or when the FIFO is empty.
- **Simultaneous push and pop:** allowed when not full; occupancy is unchanged. A push is never accepted while full, even if a pop occurs the same cycle.
- **Ordering:** debug entries are written in FIFO order. No ordering is guaranteed between writeback and debug writes to the same register.
- **Reset (synchronous, takes effect at any point, including mid-operation):**
  - Clears FIFO pointers, occupancy, starve counter, `wr_en_out`, `rd_addr_out`, `rd_out` to 0.
  - Buffered debug entries are discarded and never written.
  - While `reset_in` is high, `wb_ready_out = 0` and `dbg_ready_out = 0`.

## Timing
- **Reset values:** `wr_en_out` 0, `rd_addr_out` 0, `rd_out` 0, `dbg_pending_out` 0, `busy_out` 0. In the first cycle after reset, `dbg_ready_out` is 1 and `wb_ready_out` is 1.
- **Writeback latency:** accepted in cycle N, `wr_en_out` is high in cycle N+1, and the register file captures the write at the end of N+1.
- **Debug latency:** minimum is push in N, grant in N+1, `wr_en_out` in N+2. With the guard enabled and writeback continuously valid, the worst case is push in N, forced grant in N+STARVE_LIMIT+1, write in N+STARVE_LIMIT+2.
- **Combinational outputs:** `wb_ready_out` and `dbg_ready_out` are combinational from registered state plus `reset_in`. There is no combinational path from `*_valid_in` to any ready output.
- **Throughput:** one register-file write per cycle maximum.

## Configuration
- **`MSRV32_RF_STARVE_GUARD_EN` defined:** the starve counter and forced debug grant are present as described above.
- **`MSRV32_RF_STARVE_GUARD_EN` undefined:**
  - Strict priority: writeback always wins and `wb_ready_out` is 1 outside reset.
  - The debug FIFO drains only in cycles with `wb_valid_in = 0`.
  - The counter logic is removed and `STARVE_LIMIT` is unused.

## Test plan
- **Writeback write:** reset, then `wb_valid_in`=1, addr 2, data 0x12345678 for one cycle. Next cycle: `wr_en_out`=1, `rd_addr_out`=2, `rd_out`=0x12345678. The following cycle: `wr_en_out`=0. The register file then reads 0x12345678 on x2.
- **x0 filter:** writeback to x0 with data 0xDEADBEEF gives `wb_ready_out`=1 and `wr_en_out` remains 0. Debug push to x0 pops (`dbg_pending_out` 1→0) with no write.
- **FIFO full (guard off):** `wb_valid_in` held 1, two debug pushes (x5=0xA, x6=0xB). Result: `dbg_pending_out`=2, `dbg_ready_out`=0, third push not accepted. After dropping `wb_valid_in`: writes x5=0xA then x6=0xB on consecutive cycles, `busy_out` falls after the last write.
- **Starvation guard (on, STARVE_LIMIT=4):** `wb_valid_in` held 1 with one debug entry x7=0x77. Expected: four writeback grants, then one cycle with `wb_ready_out`=0 and a debug grant, then `wr_en_out`=1, addr 7, data 0x77. Writeback resumes the next cycle.
- **Simultaneous push/pop:** occupancy 1, writeback idle, push in the same cycle. The head is popped, the new entry is stored, and `dbg_pending_out` stays 1.
- **Reset mid-operation:** occupancy 2 with `wr_en_out`=1, assert `reset_in` for one cycle. Following edge: all outputs 0, occupancy 0, and neither buffered entry is ever written.
